// File: rtl/pipe_stall_ctrl_if.sv
// rtl/pipe_stall_ctrl_if.sv - stall request / stall vector bundle for the core's stall controller
// Purpose: groups the stage stall requests, the EX multi-cycle handshake and
//          the resulting stall vector between the pipeline and pipe_stall_ctrl.
// Ports (signals):
//   stallreq_if/id/ex/mem  per-stage stall requests (pipeline -> ctrl)
//   mc_start, mc_len       EX multi-cycle op present, and its length (pipeline -> ctrl)
//   mc_cancel              flush of the multi-cycle op (pipeline -> ctrl)
//   stall[5:0]             per-register Stop vector (ctrl -> pipeline)
//   mc_busy, mc_cnt        sequencer active, current step index (ctrl -> pipeline)
//   mc_done                EX multi-cycle result valid this cycle (ctrl -> pipeline)
// Modports: master = pipeline side, slave = stall controller.
interface pipe_stall_ctrl_if #(
  parameter int LEN_W = 6
);
  logic             stallreq_if;
  logic             stallreq_id;
  logic             stallreq_ex;
  logic             stallreq_mem;
  logic             mc_start;
  logic [LEN_W-1:0] mc_len;
  logic             mc_cancel;
  logic [5:0]       stall;
  logic             mc_busy;
  logic [LEN_W-1:0] mc_cnt;
  logic             mc_done;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output mc_start, mc_len, mc_cancel,
    input  stall, mc_busy, mc_cnt, mc_done
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  mc_start, mc_len, mc_cancel,
    output stall, mc_busy, mc_cnt, mc_done
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - central stall controller with EX multi-cycle sequencer
// Purpose: merges IF/ID/EX/MEM stall requests into the 6-bit stall vector
//          (deepest request wins) and sequences multi-cycle EX ops, holding EX
//          for L cycles and presenting the result (mc_done) until EX/MEM takes it.
// Ports:
//   clk   clock
//   rst   synchronous, active-high reset
//   bus   pipe_stall_ctrl_if.slave: requests and mc_start/mc_len/mc_cancel in;
//         stall, mc_busy, mc_cnt, mc_done out
module pipe_stall_ctrl #(
  parameter int LEN_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  pipe_stall_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic             busy_q;

  logic [LEN_W-1:0] len_eff;
  logic             start_ok;
  logic             seq_req;
  logic [5:0]       stall_v;

  // A length of zero behaves like a single-cycle hold.
  assign len_eff  = (bus.mc_len == '0) ? LEN_W'(1) : bus.mc_len;
  assign start_ok = (state == S_IDLE) && bus.mc_start && !bus.mc_cancel;

  // The start cycle already stalls (Mealy), so L hold cycles total T..T+L-1.
  assign seq_req = !bus.mc_cancel && (start_ok || (state == S_RUN));

  always_comb begin
    stall_v = 6'b000000;
    if (bus.stallreq_mem)                stall_v = 6'b011111;
    else if (bus.stallreq_ex || seq_req) stall_v = 6'b001111;
    else if (bus.stallreq_id)            stall_v = 6'b000111;
    else if (bus.stallreq_if)            stall_v = 6'b000011;
  end

  assign bus.stall   = rst ? 6'b000000 : stall_v;
  assign bus.mc_done = !rst && !bus.mc_cancel && (state == S_DONE);
  assign bus.mc_busy = busy_q;
  assign bus.mc_cnt  = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt_q  <= '0;
      len_q  <= '0;
      busy_q <= 1'b0;
    end else if (bus.mc_cancel) begin
      state  <= S_IDLE;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            len_q  <= len_eff;
            cnt_q  <= LEN_W'(1);
            busy_q <= 1'b1;
            state  <= (len_eff > LEN_W'(1)) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          // Counts on even under other stalls: EX is frozen either way.
          // Leaving at L-1 lands cnt on L in DONE and can never wrap.
          cnt_q <= cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) state <= S_DONE;
        end
        S_DONE: begin
          // Only release once EX/MEM actually captures the result.
          if (!stall_v[3]) begin
            state  <= S_IDLE;
            cnt_q  <= '0;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          cnt_q  <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - scoreboard testbench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;

  localparam int LEN_W = 6;

  logic clk;
  logic rst;

  pipe_stall_ctrl_if #(.LEN_W(LEN_W)) bus ();

  pipe_stall_ctrl #(.LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]       stall;
    logic             done;
    logic             busy;
    logic [LEN_W-1:0] cnt;
    logic             chk_state;
    string            name;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: compares every cycle for which the driver queued an expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, ".stall"}, 32'(bus.stall), 32'(e.stall));
        chk({e.name, ".mc_done"}, 32'(bus.mc_done), 32'(e.done));
        if (e.chk_state) begin
          chk({e.name, ".mc_busy"}, 32'(bus.mc_busy), 32'(e.busy));
          chk({e.name, ".mc_cnt"}, 32'(bus.mc_cnt), 32'(e.cnt));
        end
      end
    end
  end

  // One cycle of stimulus with its hand-computed expected outputs.
  task automatic v(input logic r, input logic i_if, input logic i_id, input logic i_ex,
                   input logic i_mem, input logic st, input logic [LEN_W-1:0] ln,
                   input logic cn, input logic [5:0] es, input logic ed, input logic eb,
                   input logic [LEN_W-1:0] ec, input logic ck, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst              = r;
    bus.stallreq_if  = i_if;
    bus.stallreq_id  = i_id;
    bus.stallreq_ex  = i_ex;
    bus.stallreq_mem = i_mem;
    bus.mc_start     = st;
    bus.mc_len       = ln;
    bus.mc_cancel    = cn;
    e.stall     = es;
    e.done      = ed;
    e.busy      = eb;
    e.cnt       = ec;
    e.chk_state = ck;
    e.name      = nm;
    sb.push_back(e);
  endtask

  initial begin
    rst              = 1'b1;
    bus.stallreq_if  = 1'b0;
    bus.stallreq_id  = 1'b0;
    bus.stallreq_ex  = 1'b0;
    bus.stallreq_mem = 1'b0;
    bus.mc_start     = 1'b0;
    bus.mc_len       = '0;
    bus.mc_cancel    = 1'b0;

    // Reset: stall gated to zero even with a mem request pending.
    //  r  if id ex mem st len cn  stall      done busy cnt chk
    v(1, 0, 0, 0, 0, 0, 6'd0, 0, 6'h00, 0, 0, 6'd0, 1, "rst0");
    v(1, 0, 0, 0, 1, 0, 6'd0, 0, 6'h00, 0, 0, 6'd0, 1, "rst_mem");

    // Priority merge.
    v(0, 1, 1, 0, 0, 0, 6'd0, 0, 6'h07, 0, 0, 6'd0, 1, "pri_if_id");
    v(0, 1, 1, 0, 1, 0, 6'd0, 0, 6'h1F, 0, 0, 6'd0, 1, "pri_mem");
    v(0, 1, 0, 1, 0, 0, 6'd0, 0, 6'h0F, 0, 0, 6'd0, 1, "pri_ex");
    v(0, 1, 0, 0, 0, 0, 6'd0, 0, 6'h03, 0, 0, 6'd0, 1, "pri_if");
    v(0, 0, 0, 0, 0, 0, 6'd0, 0, 6'h00, 0, 0, 6'd0, 1, "pri_none");

    // L=2, mc_start held through DONE must not retrigger.
    v(0, 0, 0, 0, 0, 1, 6'd2, 0, 6'h0F, 0, 0, 6'd0, 1, "l2_t0");
    v(0, 0, 0, 0, 0, 1, 6'd2, 0, 6'h0F, 0, 1, 6'd1, 1, "l2_t1");
    v(0, 0, 0, 0, 0, 1, 6'd2, 0, 6'h00, 1, 1, 6'd2, 1, "l2_done");
    v(0, 0, 0, 0, 0, 0, 6'd2, 0, 6'h00, 0, 0, 6'd0, 1, "l2_idle");

    // L=0 and L=1 both give a single stall cycle.
    v(0, 0, 0, 0, 0, 1, 6'd0, 0, 6'h0F, 0, 0, 6'd0, 1, "l0_t0");
    v(0, 0, 0, 0, 0, 1, 6'd0, 0, 6'h00, 1, 1, 6'd1, 1, "l0_done");
    v(0, 0, 0, 0, 0, 0, 6'd0, 0, 6'h00, 0, 0, 6'd0, 1, "l0_idle");
    v(0, 0, 0, 0, 0, 1, 6'd1, 0, 6'h0F, 0, 0, 6'd0, 1, "l1_t0");
    v(0, 0, 0, 0, 0, 1, 6'd1, 0, 6'h00, 1, 1, 6'd1, 1, "l1_done");
    v(0, 0, 0, 0, 0, 0, 6'd1, 0, 6'h00, 0, 0, 6'd0, 1, "l1_idle");

    // L=63: 63 stall cycles, cnt 1..62 in RUN, 63 in DONE.
    v(0, 0, 0, 0, 0, 1, 6'd63, 0, 6'h0F, 0, 0, 6'd0, 1, "l63_t0");
    for (int k = 1; k <= 62; k++)
      v(0, 0, 0, 0, 0, 1, 6'd63, 0, 6'h0F, 0, 1, 6'(k), 1, "l63_run");
    v(0, 0, 0, 0, 0, 1, 6'd63, 0, 6'h00, 1, 1, 6'd63, 1, "l63_done");
    v(0, 0, 0, 0, 0, 0, 6'd63, 0, 6'h00, 0, 0, 6'd0, 1, "l63_idle");

    // Mem stall holds DONE for three cycles.
    v(0, 0, 0, 0, 0, 1, 6'd2, 0, 6'h0F, 0, 0, 6'd0, 1, "hold_t0");
    v(0, 0, 0, 0, 0, 1, 6'd2, 0, 6'h0F, 0, 1, 6'd1, 1, "hold_t1");
    v(0, 0, 0, 0, 1, 1, 6'd2, 0, 6'h1F, 1, 1, 6'd2, 1, "hold_m1");
    v(0, 0, 0, 0, 1, 1, 6'd2, 0, 6'h1F, 1, 1, 6'd2, 1, "hold_m2");
    v(0, 0, 0, 0, 1, 1, 6'd2, 0, 6'h1F, 1, 1, 6'd2, 1, "hold_m3");
    v(0, 0, 0, 0, 0, 1, 6'd2, 0, 6'h00, 1, 1, 6'd2, 1, "hold_rel");
    v(0, 0, 0, 0, 0, 0, 6'd2, 0, 6'h00, 0, 0, 6'd0, 1, "hold_idle");

    // Cancel at cnt=3 of L=8, then an immediate restart with L=1.
    v(0, 0, 0, 0, 0, 1, 6'd8, 0, 6'h0F, 0, 0, 6'd0, 1, "cn_t0");
    v(0, 0, 0, 0, 0, 1, 6'd8, 0, 6'h0F, 0, 1, 6'd1, 1, "cn_t1");
    v(0, 0, 0, 0, 0, 1, 6'd8, 0, 6'h0F, 0, 1, 6'd2, 1, "cn_t2");
    v(0, 0, 0, 0, 0, 1, 6'd8, 1, 6'h00, 0, 1, 6'd3, 1, "cn_cancel");
    v(0, 0, 0, 0, 0, 1, 6'd1, 0, 6'h0F, 0, 0, 6'd0, 1, "cn_restart");
    v(0, 0, 0, 0, 0, 1, 6'd1, 0, 6'h00, 1, 1, 6'd1, 1, "cn_done");
    v(0, 0, 0, 0, 0, 0, 6'd1, 0, 6'h00, 0, 0, 6'd0, 1, "cn_idle");

    // Cancel beats start in IDLE.
    v(0, 0, 0, 0, 0, 1, 6'd4, 1, 6'h00, 0, 0, 6'd0, 1, "cn_prio");
    v(0, 0, 0, 0, 0, 0, 6'd4, 0, 6'h00, 0, 0, 6'd0, 1, "cn_prio_idle");

    // Reset for one cycle mid-RUN.
    v(0, 0, 0, 0, 0, 1, 6'd5, 0, 6'h0F, 0, 0, 6'd0, 1, "rr_t0");
    v(0, 0, 0, 0, 0, 1, 6'd5, 0, 6'h0F, 0, 1, 6'd1, 1, "rr_t1");
    v(1, 0, 0, 0, 0, 1, 6'd5, 0, 6'h00, 0, 0, 6'd0, 0, "rr_rst");
    v(0, 0, 0, 0, 0, 0, 6'd5, 0, 6'h00, 0, 0, 6'd0, 1, "rr_idle");
    v(0, 0, 0, 0, 0, 0, 6'd5, 0, 6'h00, 0, 0, 6'd0, 1, "rr_quiet");

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
    @(posedge clk);
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
